// File: rtl/generic_sync_fifo_if.sv
// Producer/consumer bundle for generic_sync_fifo: write/read requests, flush, data, level and flags.
interface generic_sync_fifo_if #(
  parameter int aw = 4,
  parameter int dw = 16
);
  logic          clr;
  logic          wr_en;
  logic [dw-1:0] din;
  logic          rd_en;
  logic [dw-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [aw:0]   level;
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/generic_sync_fifo.sv
// Single-clock FIFO on an inferred dual-port RAM; 1-cycle read latency, or first-word-fall-through
// when GENERIC_SYNC_FIFO_FWFT_EN is defined. Writes while full / reads while empty are dropped and pulse overflow / underflow.
module generic_sync_fifo #(
  parameter int aw         = 4,
  parameter int dw         = 16,
  parameter int afull_thr  = 12,
  parameter int aempty_thr = 2
) (
  input  logic                clk,
  input  logic                rst,
  generic_sync_fifo_if.slave  bus
);
  localparam int          depth  = 1 << aw;
  localparam logic [aw:0] depth_l = (aw+1)'(depth);
  localparam logic [aw:0] af_lim  = (aw+1)'(afull_thr);
  localparam logic [aw:0] ae_lim  = (aw+1)'(aempty_thr);

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wp, rp;
  logic [aw:0]   lvl, lvl_nxt;
  logic          wr_acc, rd_acc;
  logic          full_q, af_q, ae_q, ovf_q, udf_q;
  logic [dw-1:0] dout_q;
  logic          avail;

  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && avail;

  always_comb begin
    lvl_nxt = lvl;
    if (wr_acc && !rd_acc)
      lvl_nxt = lvl + 1'b1;
    else if (rd_acc && !wr_acc)
      lvl_nxt = lvl - 1'b1;
  end

  // RAM has no reset; stale contents are never read because reads are gated by level.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wp] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      wp     <= '0;
      lvl    <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ae_q   <= 1'b1;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc)
        wp <= wp + 1'b1;
      lvl    <= lvl_nxt;
      full_q <= (lvl_nxt == depth_l);
      af_q   <= (lvl_nxt >= af_lim);
      ae_q   <= (lvl_nxt <= ae_lim);
      ovf_q  <= bus.wr_en && full_q;
      udf_q  <= bus.rd_en && !avail;
    end
  end

`ifdef GENERIC_SYNC_FIFO_FWFT_EN
  // Two-stage output: s1 holds the RAM read, dout_q is the head word shown to the consumer.
  logic [dw-1:0] s1_q;
  logic          s1_vld, head_vld;
  logic [aw:0]   ram_cnt;
  logic          head_load, s1_load;

  assign avail     = head_vld;
  assign ram_cnt   = lvl - {{aw{1'b0}}, s1_vld} - {{aw{1'b0}}, head_vld};
  assign head_load = s1_vld && (!head_vld || rd_acc);
  assign s1_load   = (ram_cnt != '0) && (!s1_vld || head_load);

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      rp       <= '0;
      s1_q     <= '0;
      s1_vld   <= 1'b0;
      head_vld <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_q   <= mem[rp];
        rp     <= rp + 1'b1;
        s1_vld <= 1'b1;
      end else if (head_load) begin
        s1_vld <= 1'b0;
      end
      if (head_load) begin
        dout_q   <= s1_q;
        head_vld <= 1'b1;
      end else if (rd_acc) begin
        head_vld <= 1'b0;
      end
    end
  end

  assign bus.empty = !head_vld;
`else
  logic empty_q;

  assign avail = !empty_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      rp      <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
    end else begin
      if (rd_acc) begin
        dout_q <= mem[rp];
        rp     <= rp + 1'b1;
      end
      empty_q <= (lvl_nxt == '0);
    end
  end

  assign bus.empty = empty_q;
`endif

  assign bus.dout         = dout_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = lvl;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_generic_sync_fifo.sv
// Directed bench for generic_sync_fifo (aw=3, dw=8, afull_thr=6, aempty_thr=1).
module tb_generic_sync_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  generic_sync_fifo_if #(.aw(3), .dw(8)) bus ();

  generic_sync_fifo #(.aw(3), .dw(8), .afull_thr(6), .aempty_thr(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int lvl, input bit e, input bit f,
                           input bit ae, input bit af);
    chk({tag, ".level"}, 32'(bus.level), 32'(lvl));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(e));
    chk({tag, ".full"},  32'(bus.full),  32'(f));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(ae));
    chk({tag, ".afull"},  32'(bus.almost_full),  32'(af));
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_flags("reset", 0, 1, 0, 1, 0);
    chk("reset.dout", 32'(bus.dout), 0);
    chk("reset.ovf",  32'(bus.overflow), 0);
    chk("reset.udf",  32'(bus.underflow), 0);

`ifdef GENERIC_SYNC_FIFO_FWFT_EN
    bus.wr_en = 1'b1; bus.din = 8'h33;
    tick();
    chk_flags("fwft.e0", 1, 1, 0, 1, 0);
    bus.din = 8'h44;
    tick();
    bus.wr_en = 1'b0;
    chk_flags("fwft.e1", 2, 1, 0, 0, 0);
    tick();
    chk_flags("fwft.e2", 2, 0, 0, 0, 0);
    chk("fwft.head0", 32'(bus.dout), 32'h33);
    bus.rd_en = 1'b1;
    tick();
    chk("fwft.head1", 32'(bus.dout), 32'h44);
    chk_flags("fwft.pop1", 1, 0, 0, 1, 0);
    tick();
    bus.rd_en = 1'b0;
    chk_flags("fwft.pop2", 0, 1, 0, 1, 0);
    chk("fwft.udf0", 32'(bus.underflow), 0);
`else
    // fill to full
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(i);
      tick();
      chk_flags($sformatf("fill%0d", i), i, 0, (i == 8), (i <= 1), (i >= 6));
    end
    bus.din = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf.pulse", 32'(bus.overflow), 1);
    chk("ovf.level", 32'(bus.level), 8);
    tick();
    chk("ovf.clear", 32'(bus.overflow), 0);

    // drain in order
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("drain%0d.dout", i), 32'(bus.dout), 32'(i));
      chk($sformatf("drain%0d.level", i), 32'(bus.level), 32'(8 - i));
    end
    chk_flags("drained", 0, 1, 0, 1, 0);

    // read while empty
    tick();
    bus.rd_en = 1'b0;
    chk("udf.pulse", 32'(bus.underflow), 1);
    chk("udf.dout",  32'(bus.dout), 32'h08);
    chk("udf.level", 32'(bus.level), 0);
    tick();
    chk("udf.clear", 32'(bus.underflow), 0);

    // streaming across pointer wrap, level held at 3
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(8'h10 + i);
      tick();
    end
    for (int i = 3; i < 20; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(8'h10 + i); bus.rd_en = 1'b1;
      tick();
      chk($sformatf("stream%0d.dout", i), 32'(bus.dout), 32'(8'h10 + i - 3));
      chk_flags($sformatf("stream%0d", i), 3, 0, 0, 0, 0);
    end
    bus.wr_en = 1'b0;
    for (int i = 17; i < 20; i++) begin
      tick();
      chk($sformatf("tail%0d.dout", i), 32'(bus.dout), 32'(8'h10 + i));
    end
    bus.rd_en = 1'b0;
    chk("tail.empty", 32'(bus.empty), 1);

    // flush mid-stream
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(8'h60 + i);
      tick();
    end
    bus.wr_en = 1'b0; bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk_flags("clr", 0, 1, 0, 1, 0);
    chk("clr.dout", 32'(bus.dout), 0);
    bus.wr_en = 1'b1; bus.din = 8'h55;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("clr.rd", 32'(bus.dout), 32'h55);
    chk("clr.empty", 32'(bus.empty), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
